mc_cpu_core: RTL and testbench
==============================

Name: mc_cpu_core

Overview:
- Parametrised, fully synchronous multi-cycle CPU core.
- Contains a unified instruction/data memory, a program counter, an instruction register, an ALU and a fetch/read/execute FSM.
- Generalised in data width, memory depth and opcode set; adds a host load port, start/halt control and conditional jumps.
- Sits as the top compute block; a host or testbench preloads memory, pulses start, then polls halted.

Parameters:
- DATA_W, 32: memory word and ALU width; must be >= 4 + 3*ADDR_W.
- ADDR_W, 4: memory address width; depth = 2**ADDR_W words.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ld_we  in  1  host write strobe; honoured only in IDLE or HALT.
- ld_addr  in  ADDR_W  host write address.
- ld_data  in  DATA_W  host write data.
- start  in  1  one-cycle pulse; begins execution at start_pc.
- start_pc  in  ADDR_W  first instruction address.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  combinational mem[dbg_addr].
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in FETCH, READ_A, READ_B and EXEC.
- halted  out  1  high in HALT.
- alu_out  out  DATA_W  last EXEC result, registered.

Behaviour:
- Instruction fields, with A = ADDR_W:
  - op = instr[3A+3:3A]
  - rd = instr[3A-1:2A]
  - ra = instr[2A-1:A]
  - rb = instr[A-1:0]
  - Upper bits are ignored.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: mem[rd] <= mem[ra] op mem[rb].
  - 5 JMP: pc <= rb.
  - 6 JZ: pc <= rb if mem[ra]==0, else pc+1.
  - 7 HALT.
  - 8-15: NOP.
- Arithmetic: modulo 2**DATA_W; carries and borrows are discarded.
- FSM states and transitions:
  - IDLE -> FETCH on start.
  - FETCH: ir <= mem[pc].
  - READ_A: a <= mem[ra].
  - READ_B: b <= mem[rb].
  - EXEC: register alu_out, write mem[rd] for ALU ops, update pc. Next state is FETCH, or HALT for op 7.
  - HALT -> FETCH on start.
  - Every instruction takes exactly 4 cycles.
- Memory read is combinational from the array; memory write is synchronous in EXEC.
- Memory is not cleared by reset. The only memory writers are the EXEC writeback and the load port.
- PC:
  - Increments modulo 2**ADDR_W; after address 2**ADDR_W-1 it wraps to 0.
  - HALT leaves pc pointing at the HALT instruction.
  - alu_out is updated for ALU ops only.
- Reset values: state IDLE, pc 0, ir 0, alu_out 0, busy 0, halted 0. Reset mid-instruction aborts it with no memory write.
- Simultaneous events:
  - ld_we and start in the same IDLE/HALT cycle: the write lands at that edge, so the first FETCH sees the new data.
  - start while busy: ignored.
  - ld_we while busy: ignored.
  - rd == ra or rd == rb: operands are already latched, so the old values are used.
  - An instruction that overwrites itself or the next instruction: the change takes effect from the next FETCH.

Optional Feature:
- Macro: MC_CPU_PERF_CNT_EN.
- Defined: adds output retired_cnt [31:0], reset to 0. It increments once per EXEC, including NOP, JMP, JZ and HALT, and wraps at 2**32. It clears on start.
- Undefined: no port and no counter logic.

Decomposition:
- Package mc_cpu_pkg holds:
  - opcode localparams OP_ADD .. OP_HALT;
  - the FSM state encoding (IDLE, FETCH, READ_A, READ_B, EXEC, HALT);
  - field-extraction functions parametrised by ADDR_W.
- One sub-module, mc_cpu_alu: purely combinational, (op, a, b) -> result of width DATA_W.
- The FSM, PC and memory stay in mc_cpu_core.

Test Plan:
- ADD: load mem[3]=5, mem[4]=7, mem[0]=ADD rd=5 ra=3 rb=4, mem[1]=HALT; start_pc=0 -> mem[5]=12, alu_out=12. halted rises 8 cycles after start; pc=1.
- SUB wrap: mem[3]=0, mem[4]=1, SUB rd=5 -> mem[5]=0xFFFFFFFF.
- JZ: mem[2]=0, JZ ra=2 rb=9 at addr 0, with HALT at 9 -> pc goes 0->9, halted, pc=9. Repeat with mem[2]=1 -> pc goes to 1.
- PC wrap: NOP at 15 and HALT at 0, start_pc=15 -> pc 15->0, halted.
- Reset mid-EXEC: assert reset during EXEC of ADD rd=5 -> mem[5] unchanged, busy=0, pc=0. Load during busy is ignored (dbg_data unchanged).
- Perf counter (MC_CPU_PERF_CNT_EN): 3 NOPs then HALT -> retired_cnt=4. A restart clears it to 0 first.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// rtl/mc_cpu_pkg.sv - opcodes, FSM state encoding and instruction field helpers for mc_cpu_core
package mc_cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_JZ   = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  typedef enum logic [2:0] {IDLE, FETCH, READ_A, READ_B, EXEC, HALT} state_t;

  // Instructions are zero-extended into this container before field extraction.
  localparam int unsigned INSTR_MAX_W = 64;
  typedef logic [INSTR_MAX_W-1:0] instr_t;

  function automatic logic [3:0] instr_op(input instr_t instr, input int unsigned aw);
    instr_t s;
    s = instr >> (3 * aw);
    return s[3:0];
  endfunction

  // idx selects the register field: 0 = rb, 1 = ra, 2 = rd
  function automatic instr_t instr_reg(input instr_t instr, input int unsigned aw,
                                       input int unsigned idx);
    instr_t mask;
    mask = (instr_t'(1) << aw) - instr_t'(1);
    return (instr >> (idx * aw)) & mask;
  endfunction

endpackage

// File: rtl/mc_cpu_alu.sv
// rtl/mc_cpu_alu.sv - combinational ALU for mc_cpu_core (ADD/SUB/AND/OR/XOR, modulo 2**DATA_W)
module mc_cpu_alu
  import mc_cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mc_cpu_core.sv
// rtl/mc_cpu_core.sv - multi-cycle CPU core; MC_CPU_PERF_CNT_EN adds the retired_cnt output
module mc_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [DATA_W-1:0] alu_out
`ifdef MC_CPU_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt
);
`else
);
`endif

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state, state_nx;
  logic [DATA_W-1:0] ir, a, b, alu_res;
  logic [3:0]        op;
  logic [ADDR_W-1:0] rd, ra, rb, pc_nx;
  logic              is_alu, host_ok, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign op      = instr_op(instr_t'(ir), ADDR_W);
  assign rd      = ADDR_W'(instr_reg(instr_t'(ir), ADDR_W, 2));
  assign ra      = ADDR_W'(instr_reg(instr_t'(ir), ADDR_W, 1));
  assign rb      = ADDR_W'(instr_reg(instr_t'(ir), ADDR_W, 0));
  assign is_alu  = (op <= OP_XOR);
  assign host_ok = (state == IDLE) || (state == HALT);

  assign busy     = (state == FETCH) || (state == READ_A) || (state == READ_B) || (state == EXEC);
  assign halted   = (state == HALT);
  assign dbg_data = mem[dbg_addr];

  mc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (alu_res)
  );

  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
    case (state)
      IDLE, HALT: begin
        mem_we = ld_we;
        if (start) begin
          state_nx = FETCH;
          pc_nx    = start_pc;
        end
      end
      FETCH:  state_nx = READ_A;
      READ_A: state_nx = READ_B;
      READ_B: state_nx = EXEC;
      EXEC: begin
        state_nx = (op == OP_HALT) ? HALT : FETCH;
        case (op)
          OP_JMP:  pc_nx = rb;
          OP_JZ:   pc_nx = (a == '0) ? rb : pc + ADDR_W'(1);
          OP_HALT: pc_nx = pc;
          default: pc_nx = pc + ADDR_W'(1);
        endcase
        if (is_alu) begin
          mem_we    = 1'b1;
          mem_waddr = rd;
          mem_wdata = alu_res;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (state == FETCH)  ir <= mem[pc];
      if (state == READ_A) a  <= mem[ra];
      if (state == READ_B) b  <= mem[rb];
      if (state == EXEC && is_alu) alu_out <= alu_res;
    end
  end

  // No reset: contents survive reset, and async reset leaves EXEC before the next edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef MC_CPU_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  retired_cnt <= '0;
    else if (host_ok && start)  retired_cnt <= '0;
    else if (state == EXEC)     retired_cnt <= retired_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mc_cpu_core.sv
// tb/tb_mc_cpu_core.sv - self-checking bench for mc_cpu_core: vector table, directed corners, random programs
module tb_mc_cpu_core;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic [DW-1:0] alu_out;
`ifdef MC_CPU_PERF_CNT_EN
  logic [31:0]   retired_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mc_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .start    (start),
    .start_pc (start_pc),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted),
`ifdef MC_CPU_PERF_CNT_EN
    .retired_cnt (retired_cnt),
`endif
    .alu_out  (alu_out)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] ra, input logic [3:0] rb);
    return {16'h0000, op, rd, ra, rb};
  endfunction

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
    case (op)
      4'd0:    return x + y;
      4'd1:    return x - y;
      4'd2:    return x & y;
      4'd3:    return x | y;
      default: return x ^ y;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic load(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic peek(input logic [3:0] addr, output logic [31:0] d);
    dbg_addr = addr;
    #1;
    d = dbg_data;
  endtask

  task automatic do_start(input logic [3:0] spc);
    @(negedge clk);
    start = 1'b1; start_pc = spc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(output int cycles);
    cycles = 0;
    while (!halted && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    if (!halted) check("halt_timeout", {31'd0, halted}, 32'd1);
  endtask

  task automatic run(input logic [3:0] spc, output int cycles);
    do_start(spc);
    wait_halt(cycles);
  endtask

  localparam logic [31:0] HLT = 32'h0000_7000;
  localparam logic [31:0] NOP = 32'h0000_8000;

  initial begin
    vec_t        tbl[6];
    logic [31:0] d;
    int          cyc;
    logic [31:0] m[16];
    logic [3:0]  pcm, mop;
    logic [31:0] ealu;
    int          steps;

    tbl[0] = '{4'd0, 32'd5,          32'd7,          32'd12};
    tbl[1] = '{4'd1, 32'd0,          32'd1,          32'hFFFF_FFFF};
    tbl[2] = '{4'd2, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
    tbl[3] = '{4'd3, 32'h1200_0034,  32'h0056_0000,  32'h1256_0034};
    tbl[4] = '{4'd4, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F};
    tbl[5] = '{4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0};

    repeat (2) @(negedge clk);
    check("rst_pc", {28'd0, pc}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_alu_out", alu_out, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      load(4'd3, tbl[i].a);
      load(4'd4, tbl[i].b);
      load(4'd0, enc(tbl[i].op, 4'd5, 4'd3, 4'd4));
      load(4'd1, HLT);
      run(4'd0, cyc);
      peek(4'd5, d);
      check($sformatf("vec%0d_mem5", i), d, tbl[i].exp);
      check($sformatf("vec%0d_alu_out", i), alu_out, tbl[i].exp);
      check($sformatf("vec%0d_pc", i), {28'd0, pc}, 32'd1);
      check($sformatf("vec%0d_cycles", i), cyc, 32'd8);
    end

    load(4'd2, 32'd0);
    load(4'd0, enc(4'd6, 4'd0, 4'd2, 4'd9));
    load(4'd1, HLT);
    load(4'd9, HLT);
    run(4'd0, cyc);
    check("jz_taken_pc", {28'd0, pc}, 32'd9);
    check("jz_taken_cycles", cyc, 32'd8);
    load(4'd2, 32'd1);
    run(4'd0, cyc);
    check("jz_not_taken_pc", {28'd0, pc}, 32'd1);

    load(4'd0, enc(4'd5, 4'd0, 4'd0, 4'd9));
    run(4'd0, cyc);
    check("jmp_pc", {28'd0, pc}, 32'd9);

    load(4'd15, NOP);
    load(4'd0, HLT);
    run(4'd15, cyc);
    check("wrap_pc", {28'd0, pc}, 32'd0);
    check("wrap_cycles", cyc, 32'd8);

    load(4'd6, HLT);
    load(4'd7, 32'd0);
    load(4'd0, enc(4'd0, 4'd1, 4'd6, 4'd7));
    load(4'd1, NOP);
    load(4'd2, HLT);
    run(4'd0, cyc);
    check("selfmod_pc", {28'd0, pc}, 32'd1);
    check("selfmod_cycles", cyc, 32'd8);

    load(4'd0, enc(4'd0, 4'd5, 4'd3, 4'd4));
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 4'd0; ld_data = HLT; start = 1'b1; start_pc = 4'd0;
    @(negedge clk);
    ld_we = 1'b0; start = 1'b0;
    wait_halt(cyc);
    check("ld_start_same_pc", {28'd0, pc}, 32'd0);
    check("ld_start_same_cycles", cyc, 32'd4);

    load(4'd5, 32'h0000_AAAA);
    load(4'd3, 32'd5);
    load(4'd4, 32'd7);
    load(4'd0, enc(4'd0, 4'd5, 4'd3, 4'd4));
    load(4'd1, HLT);
    do_start(4'd0);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("midexec_busy", {31'd0, busy}, 32'd0);
    check("midexec_pc", {28'd0, pc}, 32'd0);
    check("midexec_alu_out", alu_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    peek(4'd5, d);
    check("midexec_mem5", d, 32'h0000_AAAA);

    load(4'd7, 32'h0000_1234);
    do_start(4'd0);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 4'd7; ld_data = 32'hDEAD_BEEF; start = 1'b1; start_pc = 4'd9;
    @(negedge clk);
    ld_we = 1'b0; start = 1'b0;
    wait_halt(cyc);
    peek(4'd7, d);
    check("busy_load_ignored", d, 32'h0000_1234);
    check("busy_start_ignored_pc", {28'd0, pc}, 32'd1);
    peek(4'd5, d);
    check("busy_run_mem5", d, 32'd12);

`ifdef MC_CPU_PERF_CNT_EN
    load(4'd0, NOP);
    load(4'd1, NOP);
    load(4'd2, NOP);
    load(4'd3, HLT);
    run(4'd0, cyc);
    check("perf_cnt", retired_cnt, 32'd4);
    do_start(4'd0);
    check("perf_cleared", retired_cnt, 32'd0);
    wait_halt(cyc);
    check("perf_cnt_again", retired_cnt, 32'd4);
`endif

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 6; i++) begin
        if (i == 0 || $urandom_range(0, 1) == 1) mop = 4'($urandom_range(0, 4));
        else                                     mop = 4'($urandom_range(8, 15));
        m[i] = enc(mop, 4'($urandom_range(8, 15)), 4'($urandom_range(7, 15)),
                   4'($urandom_range(7, 15)));
      end
      m[6] = HLT;
      for (int i = 7; i < 16; i++) m[i] = $urandom;
      for (int i = 0; i < 16; i++) load(4'(i), m[i]);

      pcm = 4'd0;
      steps = 0;
      ealu = '0;
      while (m[pcm][15:12] != 4'd7 && steps < 32) begin
        mop = m[pcm][15:12];
        if (mop <= 4'd4) begin
          ealu = model_alu(mop, m[m[pcm][7:4]], m[m[pcm][3:0]]);
          m[m[pcm][11:8]] = ealu;
        end
        pcm = pcm + 4'd1;
        steps++;
      end

      run(4'd0, cyc);
      check($sformatf("rnd%0d_cycles", t), cyc, 32'(4 * (steps + 1)));
      check($sformatf("rnd%0d_pc", t), {28'd0, pc}, {28'd0, pcm});
      check($sformatf("rnd%0d_alu_out", t), alu_out, ealu);
      for (int i = 0; i < 16; i++) begin
        peek(4'(i), d);
        check($sformatf("rnd%0d_mem%0d", t, i), d, m[i]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
